stack_link_ctrl: RTL
====================

// Module: stack_link_ctrl
// PURPOSE
//  Multi-cycle initiator that drives the special-register write channels (SP, LR, PC) for PUSH/POP/CALL/RET.
//  Sits between decode and the special register file + data memory: reads SP/LR, performs one stack memory access, commits SP/LR/PC.
//  CALL saves the old LR on the stack before linking; RET restores it, so calls nest. Full-descending, word-aligned stack.
// PARAMETERS
//  STACK_BASE     32'h0000_1000  empty-stack SP value (pop at SP==STACK_BASE underflows)
//  STACK_LIMIT    32'h0000_0800  lowest legal stack word address (push giving SP-4 < STACK_LIMIT overflows)
//  TIMEOUT_CYCLES 16             cycles waiting for mem_ack before abort (only with STACK_TIMEOUT_EN)
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  reset       in   1   asynchronous, active-low reset
//  cmd_valid   in   1   command offered
//  cmd_ready   out  1   high only in IDLE; command accepted when valid&&ready
//  cmd_op      in   2   00 PUSH, 01 POP, 10 CALL, 11 RET
//  cmd_data    in   32  PUSH value / CALL target
//  cmd_pc      in   32  PC of issuing instruction (CALL links cmd_pc+4)
//  re_sp       in   32  current SP from special register file
//  re_lr       in   32  current LR from special register file
//  wr_sp       out  1   SP write strobe;  wr_sp_data out 32
//  wr_lr       out  1   LR write strobe;  wr_lr_data out 32
//  wr_pc       out  1   PC write strobe;  wr_pc_data out 32
//  mem_req     out  1   memory request, held until mem_ack
//  mem_we      out  1   1 write / 0 read, stable while mem_req
//  mem_addr    out  32  word address, stable while mem_req
//  mem_wdata   out  32  write data, stable while mem_req
//  mem_ack     in   1   completes request in cycle sampled high with mem_req high; ignored otherwise
//  mem_rdata   in   32  read data, valid with mem_ack
//  rsp_valid   out  1   one-cycle pulse: command finished (success or error)
//  rsp_err     out  1   qualifies rsp_valid: 1 = overflow/underflow/timeout, no register written
//  rsp_data    out  32  POP value (valid with rsp_valid, POP, !rsp_err); 0 otherwise
// BEHAVIOUR
//  Reset (async, reset==0): state IDLE, cmd_ready=1 after release, every other output 0, latches cleared; a mid-operation
//   reset drops mem_req immediately and abandons the command with no register write and no rsp_valid.
//  States: IDLE, WR (mem write pending), RD (mem read pending), COMMIT, ERR.
//  Accept in IDLE latches op, cmd_data, cmd_pc, re_sp, re_lr; bounds check uses latched SP:
//   PUSH/CALL: SP-4 < STACK_LIMIT -> ERR else WR (addr SP-4; wdata = cmd_data for PUSH, old LR for CALL).
//   POP/RET:   SP >= STACK_BASE  -> ERR else RD (addr SP).
//  WR/RD: mem_req=1 from first cycle in state until mem_ack; on ack -> COMMIT (capture mem_rdata on RD).
//  COMMIT (exactly one cycle, strobes high only here):
//   PUSH: wr_sp, SP-4.  POP: wr_sp, SP+4; rsp_data=rdata.
//   CALL: wr_sp SP-4; wr_lr cmd_pc+4; wr_pc cmd_data.
//   RET:  wr_pc old LR; wr_lr rdata; wr_sp SP+4.
//   rsp_valid=1, rsp_err=0; next state IDLE.
//  ERR (one cycle): rsp_valid=1, rsp_err=1, no strobes, no mem access; -> IDLE.
//  Minimum latency accept->rsp_valid: 3 cycles (accept, req w/ immediate ack, COMMIT); ERR path: 2 cycles.
//  cmd_ready=0 outside IDLE; commands offered while busy are not accepted (back-pressure, no loss).
//  Arithmetic modulo 2^32; low 2 bits of addresses pass through unmodified (SP alignment is caller's responsibility).
//  Back-to-back commands: IDLE after COMMIT sees updated re_sp/re_lr (strobes captured on COMMIT's closing edge).
// CONFIGURATION
//  STACK_TIMEOUT_EN defined: counter runs in WR/RD; after TIMEOUT_CYCLES cycles without ack, drop mem_req, go ERR
//   (rsp_err=1, no register write); counter clears on entering WR/RD.
//  STACK_TIMEOUT_EN undefined: no counter; WR/RD wait indefinitely for mem_ack.
// TESTING
//  SP=0x1000, PUSH 0xDEADBEEF, ack 1 cycle later -> mem write @0xFFC data 0xDEADBEEF; wr_sp=1 data 0xFFC; rsp_err=0.
//  SP=0xFFC, mem[0xFFC]=0x1234, POP -> mem read @0xFFC; wr_sp data 0x1000; rsp_data=0x1234.
//  SP=0x1000, LR=0x40, CALL pc=0x100 tgt=0x200, then RET -> write 0x40@0xFFC, LR=0x104, PC=0x200; RET: PC=0x104, LR=0x40, SP=0x1000.
//  SP=0x800 PUSH -> rsp_err=1 in 2 cycles, mem_req never high; SP=0x1000 POP -> rsp_err=1, no strobes.
//  cmd_valid held during pending WR with ack delayed 5 cycles -> cmd_ready=0 until IDLE, second cmd accepted once, after rsp.
//  reset low while mem_req=1 -> mem_req/strobes 0 same cycle; with STACK_TIMEOUT_EN no ack for 16 cycles -> rsp_err=1.

Source files
------------

// File: rtl/stack_link_if.sv
// Bundle between stack_link_ctrl and its environment (decode, special register file, data memory).
// master = the controller, slave = the environment side.
interface stack_link_if;
    // Handshakes: a command transfers on a rising edge where cmd_valid && cmd_ready are both high.
    // A memory request completes on a rising edge where mem_req && mem_ack are both high.
    // mem_we/mem_addr/mem_wdata are held stable for as long as mem_req is high.
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;
    logic [31:0] cmd_pc;
    logic [31:0] re_sp;
    logic [31:0] re_lr;
    logic        wr_sp;
    logic [31:0] wr_sp_data;
    logic        wr_lr;
    logic [31:0] wr_lr_data;
    logic        wr_pc;
    logic [31:0] wr_pc_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_data;

    modport master (
        input  cmd_valid, cmd_op, cmd_data, cmd_pc, re_sp, re_lr, mem_ack, mem_rdata,
        output cmd_ready, wr_sp, wr_sp_data, wr_lr, wr_lr_data, wr_pc, wr_pc_data,
               mem_req, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_err, rsp_data
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_data, cmd_pc, re_sp, re_lr, mem_ack, mem_rdata,
        input  cmd_ready, wr_sp, wr_sp_data, wr_lr, wr_lr_data, wr_pc, wr_pc_data,
               mem_req, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_err, rsp_data
    );
endinterface

// File: rtl/stack_link_ctrl.sv
// PUSH/POP/CALL/RET sequencer: one stack memory access, then a single-cycle SP/LR/PC commit.
// Optional STACK_TIMEOUT_EN aborts a memory access that is not acknowledged in time.
module stack_link_ctrl #(
    parameter logic [31:0] STACK_BASE     = 32'h0000_1000,
    parameter logic [31:0] STACK_LIMIT    = 32'h0000_0800,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    stack_link_if.master      bus,
    output logic [2:0]        dbg_state_o
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR     = 3'd1,
        S_RD     = 3'd2,
        S_COMMIT = 3'd3,
        S_ERR    = 3'd4
    } state_e;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] data_q, data_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] sp_q, sp_d;
    logic [31:0] lr_q, lr_d;
    logic [31:0] rdata_q, rdata_d;

    logic        accept;
    logic        push_like;
    logic        push_ovf;
    logic        pop_unf;
    logic        busy;
    logic        tmo_expired;
    logic [31:0] sp_dec;
    logic [31:0] sp_inc;

    assign accept    = (state_q == S_IDLE) && bus.cmd_valid;
    // PUSH and CALL both store a word below SP; POP and RET both load the word at SP.
    assign push_like = ~bus.cmd_op[0];
    assign push_ovf  = (bus.re_sp - 32'd4) < STACK_LIMIT;
    assign pop_unf   = bus.re_sp >= STACK_BASE;
    assign busy      = (state_q == S_WR) || (state_q == S_RD);
    assign sp_dec    = sp_q - 32'd4;
    assign sp_inc    = sp_q + 32'd4;
    assign dbg_state_o = state_q;

`ifdef STACK_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Counter sits at zero outside WR/RD, so entering either state starts from a cleared count.
    assign tmo_d       = busy ? tmo_q + TMO_W'(1) : '0;
    assign tmo_expired = busy && !bus.mem_ack && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`else
    assign tmo_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    if (push_like) state_d = push_ovf ? S_ERR : S_WR;
                    else           state_d = pop_unf  ? S_ERR : S_RD;
                end
            end
            S_WR, S_RD: begin
                if (bus.mem_ack)      state_d = S_COMMIT;
                else if (tmo_expired) state_d = S_ERR;
            end
            S_COMMIT, S_ERR: state_d = S_IDLE;
            default:         state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_d    = op_q;
        data_d  = data_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        lr_d    = lr_q;
        rdata_d = rdata_q;
        if (accept) begin
            op_d   = bus.cmd_op;
            data_d = bus.cmd_data;
            pc_d   = bus.cmd_pc;
            sp_d   = bus.re_sp;
            lr_d   = bus.re_lr;
        end
        if ((state_q == S_RD) && bus.mem_ack) rdata_d = bus.mem_rdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q    <= 2'b00;
            data_q  <= '0;
            pc_q    <= '0;
            sp_q    <= '0;
            lr_q    <= '0;
            rdata_q <= '0;
        end else begin
            op_q    <= op_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            lr_q    <= lr_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        bus.cmd_ready  = 1'b0;
        bus.wr_sp      = 1'b0;
        bus.wr_sp_data = '0;
        bus.wr_lr      = 1'b0;
        bus.wr_lr_data = '0;
        bus.wr_pc      = 1'b0;
        bus.wr_pc_data = '0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.rsp_valid  = 1'b0;
        bus.rsp_err    = 1'b0;
        bus.rsp_data   = '0;
        case (state_q)
            // Ready is withheld while reset is asserted so every output reads 0 during reset.
            S_IDLE: bus.cmd_ready = reset;
            S_WR: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = sp_dec;
                bus.mem_wdata = (op_q == OP_PUSH) ? data_q : lr_q;
            end
            S_RD: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = sp_q;
            end
            S_COMMIT: begin
                bus.rsp_valid = 1'b1;
                case (op_q)
                    OP_PUSH: begin
                        bus.wr_sp      = 1'b1;
                        bus.wr_sp_data = sp_dec;
                    end
                    OP_POP: begin
                        bus.wr_sp      = 1'b1;
                        bus.wr_sp_data = sp_inc;
                        bus.rsp_data   = rdata_q;
                    end
                    OP_CALL: begin
                        bus.wr_sp      = 1'b1;
                        bus.wr_sp_data = sp_dec;
                        bus.wr_lr      = 1'b1;
                        bus.wr_lr_data = pc_q + 32'd4;
                        bus.wr_pc      = 1'b1;
                        bus.wr_pc_data = data_q;
                    end
                    default: begin
                        bus.wr_pc      = 1'b1;
                        bus.wr_pc_data = lr_q;
                        bus.wr_lr      = 1'b1;
                        bus.wr_lr_data = rdata_q;
                        bus.wr_sp      = 1'b1;
                        bus.wr_sp_data = sp_inc;
                    end
                endcase
            end
            S_ERR: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
